gan_batch_sequencer: RTL and testbench
======================================

Name: gan_batch_sequencer

Overview:
On-chip batch controller that drives the generator -> discriminator pipeline, replacing the host-driven stimulus loop.
- Accepts latent pairs (z1, z2) on a valid/ready input stream.
- Launches the generator with a one-cycle valid pulse, then waits for the discriminator's done strobe.
- Captures the nine pixels plus the score and presents them as one 160-bit beat on a valid/ready output stream.
- Sits between the host/DMA interface and the generator/discriminator pair.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT for disc_done before the case is aborted (must be >= 2)
CNT_W, 16, width of the processed-case counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  latent pair valid
s_ready  output  1  sequencer can accept a latent pair
s_z1  input  16  signed latent z1
s_z2  input  16  signed latent z2
gen_valid_in  output  1  one-cycle launch pulse to generator valid_in
gen_z1  output  16  signed z1 to generator
gen_z2  output  16  signed z2 to generator
disc_done  input  1  discriminator valid_out
i_pix_flat  input  144  generator pixels; pixN at [16*(N-1) +: 16]
i_score  input  16  signed discriminator score
m_valid  output  1  result beat valid
m_ready  input  1  downstream accepts result
m_data  output  160  [143:0] pixels in i_pix_flat order, [159:144] score
busy  output  1  state != IDLE
case_count  output  CNT_W  completed (handshaken) result beats
err_timeout  output  1  sticky timeout flag
err_clr  input  1  clears err_timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE; gen_valid_in=0, gen_z1=0, gen_z2=0, m_valid=0, m_data=0, case_count=0, err_timeout=0, timeout counter=0.
- s_ready is 0 while rst_n=0. After release, s_ready = (state==IDLE), combinational from state.
- IDLE:
  - s_valid && s_ready at edge N: register s_z1/s_z2 into gen_z1/gen_z2; go LAUNCH.
- LAUNCH:
  - gen_valid_in=1 for exactly the cycle after acceptance (N+1).
  - Clear the timeout counter; go WAIT.
- WAIT:
  - disc_done=1: register i_pix_flat/i_score into m_data; m_valid=1 from the next cycle; go OUT.
  - Otherwise the counter increments each cycle.
  - Counter == TIMEOUT_CYCLES-1 with no disc_done: set err_timeout, drop the case (no beat, case_count unchanged), go IDLE.
  - disc_done on the terminal count cycle counts as success, not a timeout.
- OUT:
  - m_valid and m_data stay stable until m_valid && m_ready.
  - On that handshake: m_valid=0, case_count+1 (wraps 2^CNT_W-1 -> 0), go IDLE.
  - m_ready already high on the first OUT cycle completes the beat in that cycle.
- disc_done outside WAIT (including LAUNCH) is ignored.
- gen_z1/gen_z2 hold their values until the next accepted pair; they are never cleared between cases.
- Best-case throughput: one case per (generator+discriminator latency + 3) cycles. No overlap: one case in flight.
- err_clr=1 clears err_timeout next edge; a simultaneous timeout set wins.
- Reset mid-operation aborts the in-flight case: no beat emitted, outputs to reset values.
- No arithmetic on data: values pass through bit-exact, signed 16-bit, no saturation.

Optional Feature:
GAN_SEQ_STATS_EN
- Defined: adds outputs o_pos_count (CNT_W) and o_max_score (16, signed).
  - o_pos_count increments on each completed beat with score > 0.
  - o_max_score holds the signed max score over completed beats; reset value 16'sh8000.
  - Both update on the OUT handshake edge and are reset only by rst_n.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Single case: z1=100, z2=-50 accepted at cycle N -> gen_valid_in high only at N+1, gen_z1=100, gen_z2=-50. Model disc_done 5 cycles later with pix1..9=1..9, score=-7 -> m_valid next cycle, m_data[15:0]=1, [143:128]=9, [159:144]=16'hFFF9, case_count=1.
- Backpressure: hold m_ready=0 for 10 cycles in OUT -> m_data stable, s_ready=0, busy=1. Raise m_ready -> one handshake, case_count+1, s_ready=1 next cycle.
- Timeout: TIMEOUT_CYCLES=8, never assert disc_done -> err_timeout=1 after 8 WAIT cycles, no m_valid, case_count unchanged, return to IDLE. err_clr pulse -> flag 0. err_clr coincident with a second timeout -> flag stays 1.
- Back-to-back batch: 4 pairs with s_valid held high, m_ready=1 -> 4 beats in input order, exactly one gen_valid_in pulse per pair, case_count=4. Stray disc_done during IDLE/LAUNCH produces no beat.
- Reset mid-WAIT: drop rst_n for 2 cycles -> all outputs 0 immediately, no beat after release. Counter wrap: CNT_W=2, 5 cases -> case_count=1.
- GAN_SEQ_STATS_EN: scores 5, -3, 12, 0 -> o_pos_count=2, o_max_score=12.

Source files
------------

// File: rtl/gan_batch_sequencer.sv
// Batch sequencer for the generator -> discriminator pipeline: accepts latent pairs,
// launches one case at a time and returns pixels+score as one beat.
// Optional statistics outputs are enabled by defining GAN_SEQ_STATS_EN.
module gan_batch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [15:0]  s_z1,
  input  logic signed [15:0]  s_z2,
  output logic                gen_valid_in,
  output logic signed [15:0]  gen_z1,
  output logic signed [15:0]  gen_z2,
  input  logic                disc_done,
  input  logic [143:0]        i_pix_flat,
  input  logic signed [15:0]  i_score,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [159:0]        m_data,
  output logic                busy,
  output logic [CNT_W-1:0]    case_count,
  output logic                err_timeout,
`ifdef GAN_SEQ_STATS_EN
  output logic [CNT_W-1:0]    o_pos_count,
  output logic signed [15:0]  o_max_score,
`endif
  input  logic                err_clr
);

  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StOut} state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [15:0]       gen_z1_q, gen_z2_q;
  logic              m_valid_q;
  logic [159:0]      m_data_q;
  logic [CNT_W-1:0]  case_count_q;
  logic              err_q;

  logic accept, capture, timeout, handshake;

  assign accept    = s_valid && s_ready;
  assign capture   = (state_q == StWait) && disc_done;
  // A done strobe on the terminal count cycle wins over the timeout.
  assign timeout   = (state_q == StWait) && !disc_done && (tmr_q == TmrLast);
  assign handshake = (state_q == StOut) && m_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait: begin
        if (disc_done) begin
          state_d = StOut;
        end else if (tmr_q == TmrLast) begin
          state_d = StIdle;
        end
      end
      StOut:    if (m_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    s_ready      = rst_n && (state_q == StIdle);
    gen_valid_in = (state_q == StLaunch);
    busy         = (state_q != StIdle);
  end

  always_comb begin
    tmr_d = tmr_q;
    if (state_q == StLaunch) begin
      tmr_d = '0;
    end else if (state_q == StWait) begin
      tmr_d = (disc_done || timeout) ? '0 : tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q        <= '0;
      gen_z1_q     <= '0;
      gen_z2_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      case_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      if (accept) begin
        gen_z1_q <= s_z1;
        gen_z2_q <= s_z2;
      end
      if (capture) begin
        m_valid_q <= 1'b1;
        m_data_q  <= {i_score, i_pix_flat};
      end else if (handshake) begin
        m_valid_q <= 1'b0;
      end
      if (handshake) begin
        case_count_q <= case_count_q + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign gen_z1      = gen_z1_q;
  assign gen_z2      = gen_z2_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign case_count  = case_count_q;
  assign err_timeout = err_q;

`ifdef GAN_SEQ_STATS_EN
  logic [CNT_W-1:0]   pos_count_q;
  logic signed [15:0] max_score_q;
  logic signed [15:0] out_score;

  assign out_score = m_data_q[159:144];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_count_q <= '0;
      max_score_q <= 16'sh8000;
    end else if (handshake) begin
      if (out_score > 16'sd0) begin
        pos_count_q <= pos_count_q + 1'b1;
      end
      if (out_score > max_score_q) begin
        max_score_q <= out_score;
      end
    end
  end

  assign o_pos_count = pos_count_q;
  assign o_max_score = max_score_q;
`endif

endmodule

// File: tb/tb_gan_batch_sequencer.sv
// Self-checking bench for gan_batch_sequencer: a per-cycle vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_gan_batch_sequencer;

  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [15:0]   s_z1 = '0;
  logic [15:0]   s_z2 = '0;
  logic          disc_done = 1'b0;
  logic [143:0]  i_pix_flat = '0;
  logic [15:0]   i_score = '0;
  logic          m_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          s_ready, gen_valid_in, m_valid, busy, err_timeout;
  logic [15:0]   gen_z1, gen_z2;
  logic [159:0]  m_data;
  logic [CW-1:0] case_count;
`ifdef GAN_SEQ_STATS_EN
  logic [CW-1:0] o_pos_count;
  logic [15:0]   o_max_score;
`endif

  gan_batch_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_z1        (s_z1),
    .s_z2        (s_z2),
    .gen_valid_in(gen_valid_in),
    .gen_z1      (gen_z1),
    .gen_z2      (gen_z2),
    .disc_done   (disc_done),
    .i_pix_flat  (i_pix_flat),
    .i_score     (i_score),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .case_count  (case_count),
    .err_timeout (err_timeout),
`ifdef GAN_SEQ_STATS_EN
    .o_pos_count (o_pos_count),
    .o_max_score (o_max_score),
`endif
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] pix_ramp(input int base);
    logic [143:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[16*k +: 16] = 16'(base + k + 1);
    return p;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; disc_done = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  logic [15:0] bscore [8];

  // Back-to-back batch: s_valid held, m_ready=1, done two cycles after launch and a
  // stray done in every LAUNCH cycle.
  task automatic batch(input int n);
    int sent = 0, got = 0, pulses = 0, done_at = -10, c = 0;
    logic acc, hs;
    s_valid = 1'b1; s_z1 = 16'(1000); s_z2 = 16'(-1000); m_ready = 1'b1;
    while (got < n && c < 200) begin
      acc = s_valid && s_ready;
      hs  = m_valid && m_ready;
      if (hs) begin
        chk($sformatf("batch_beat%0d", got), m_data, {bscore[got], pix_ramp((got + 1) * 10)});
        got++;
      end
      tick(); c++;
      if (acc) begin
        sent++;
        if (sent < n) begin
          s_z1 = 16'(1000 + sent); s_z2 = 16'(-1000 - sent);
        end else begin
          s_valid = 1'b0;
        end
      end
      if (gen_valid_in) begin
        chk($sformatf("batch_gen_z1_%0d", pulses), 160'(gen_z1), 160'(16'(1000 + pulses)));
        pulses++;
        done_at = c + 2;
      end
      disc_done  = gen_valid_in || (c == done_at);
      i_score    = (c == done_at) ? bscore[pulses-1] : 16'($urandom);
      i_pix_flat = (c == done_at) ? pix_ramp(pulses * 10) : {5{$urandom}};
    end
    disc_done = 1'b0; s_valid = 1'b0;
    chk("batch_beats", 160'(got), 160'(n));
    chk("batch_pulses", 160'(pulses), 160'(n));
    tick();
    chk("batch_no_extra", 160'(m_valid), 160'(1'b0));
  endtask

  typedef struct packed {
    logic sv, dd, mr;
    logic sr, gv, bz, mv;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [159:0] bp_exp;

    // Reset values while rst_n is low
    #2;
    chk("rst_s_ready", 160'(s_ready), 160'(1'b0));
    chk("rst_gen_valid", 160'(gen_valid_in), 160'(1'b0));
    chk("rst_m_valid", 160'(m_valid), 160'(1'b0));
    chk("rst_m_data", m_data, 160'(0));
    chk("rst_gen_z", 160'({gen_z1, gen_z2}), 160'(0));
    chk("rst_count_err", 160'({case_count, err_timeout, busy}), 160'(0));
    do_reset();

    // Single case, one row per cycle: inputs applied, then outputs after the edge
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    s_z1 = 16'(100); s_z2 = 16'(-50);
    i_pix_flat = pix_ramp(0); i_score = 16'(-7);
    for (int i = 0; i < 10; i++) begin
      s_valid = tbl[i].sv; disc_done = tbl[i].dd; m_ready = tbl[i].mr;
      tick();
      chk($sformatf("tbl%0d_outs", i), 160'({s_ready, gen_valid_in, busy, m_valid}),
          160'({tbl[i].sr, tbl[i].gv, tbl[i].bz, tbl[i].mv}));
      if (i == 0) chk("tbl_gen_z", 160'({gen_z1, gen_z2}), 160'({16'd100, 16'hFFCE}));
      if (i == 6) begin
        chk("tbl_pix1", 160'(m_data[15:0]), 160'(16'd1));
        chk("tbl_pix9", 160'(m_data[143:128]), 160'(16'd9));
        chk("tbl_score", 160'(m_data[159:144]), 160'(16'hFFF9));
      end
    end
    chk("tbl_count", 160'(case_count), 160'(2'd1));
    disc_done = 1'b0; m_ready = 1'b0;

    // Backpressure: ten cycles with m_ready low in OUT
    s_valid = 1'b1; s_z1 = 16'(7); s_z2 = 16'(8);
    tick();
    s_valid = 1'b0;
    tick();
    disc_done = 1'b1; i_pix_flat = pix_ramp(20); i_score = 16'(33);
    bp_exp = {16'(33), pix_ramp(20)};
    tick();
    disc_done = 1'b0; i_pix_flat = '0; i_score = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp%0d_data", i), m_data, bp_exp);
      chk($sformatf("bp%0d_flags", i), 160'({s_ready, busy, m_valid}), 160'(3'b011));
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("bp_release", 160'({s_ready, busy, m_valid}), 160'(3'b100));
    chk("bp_count", 160'(case_count), 160'(2'd2));

    // Timeout: exactly TO WAIT cycles without disc_done
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), 160'({busy, err_timeout}), 160'(2'b10));
    end
    tick();
    chk("to_set", 160'({err_timeout, busy, m_valid}), 160'(3'b100));
    chk("to_count", 160'(case_count), 160'(2'd2));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clear", 160'(err_timeout), 160'(1'b0));
    err_clr = 1'b1;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (TO + 1) tick();
    chk("to_set_wins", 160'({err_timeout, busy}), 160'(2'b10));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Reset in the middle of WAIT
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 160'({s_ready, gen_valid_in, busy, m_valid, err_timeout}), 160'(0));
    chk("mid_rst_data", 160'({gen_z1, gen_z2, case_count}), 160'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    disc_done = 1'b1; m_ready = 1'b1;
    tick();
    disc_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d", i), 160'({m_valid, busy}), 160'(0));
    end

    // Back-to-back five cases: 2-bit count wraps to 1
    bscore[0] = 16'(11); bscore[1] = 16'(-2); bscore[2] = 16'(300);
    bscore[3] = 16'(0);  bscore[4] = 16'h8000;
    batch(5);
    chk("wrap_count", 160'(case_count), 160'(2'd1));

    // Statistics scores 5, -3, 12, 0
    do_reset();
    bscore[0] = 16'(5); bscore[1] = 16'(-3); bscore[2] = 16'(12); bscore[3] = 16'(0);
    batch(4);
    chk("stats_case_count", 160'(case_count), 160'(2'd0));
`ifdef GAN_SEQ_STATS_EN
    chk("stats_pos", 160'(o_pos_count), 160'(2'd2));
    chk("stats_max", 160'(o_max_score), 160'(16'd12));
`endif

    // Randomized run against a transaction-level model
    do_reset();
    begin : rnd
      int acc_c = -10, launch_c = -10, done_at = -10, wait_end = -10, d, r;
      bit inflight = 0, outp = 0, exp_err = 0, timed = 0, in_wait;
      bit n_inflight, n_outp;
      logic [CW-1:0] exp_cnt = '0;
      logic [15:0] lz1 = '0, lz2 = '0;
      logic [159:0] q[$];
      for (int c = 0; c < 3000; c++) begin
        tick();
        chk("r_busy", 160'(busy), 160'(inflight));
        chk("r_s_ready", 160'(s_ready), 160'(!inflight));
        chk("r_m_valid", 160'(m_valid), 160'(outp));
        chk("r_err", 160'(err_timeout), 160'(exp_err));
        chk("r_count", 160'(case_count), 160'(exp_cnt));
        chk("r_gen_valid", 160'(gen_valid_in), 160'(c == acc_c + 1));
        chk("r_gen_z", 160'({gen_z1, gen_z2}), 160'({lz1, lz2}));
        if (outp && q.size() > 0) chk("r_m_data", m_data, q[0]);
        if (c == acc_c + 1) begin
          launch_c = c;
          r = int'($urandom_range(0, 5));
          d = (r == 0) ? TO : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
          timed = (d >= TO);
          done_at = c + 1 + d;
          wait_end = timed ? c + TO : done_at;
        end
        in_wait = inflight && (launch_c > acc_c) && (c > launch_c) && (c <= wait_end);
        disc_done  = (c == done_at) ? 1'b1 : (in_wait ? 1'b0 : ($urandom_range(0, 3) == 0));
        i_pix_flat = {5{$urandom}};
        i_score    = 16'($urandom);
        m_ready    = ($urandom_range(0, 1) == 1);
        s_valid    = ($urandom_range(0, 2) != 0);
        s_z1       = 16'($urandom);
        s_z2       = 16'($urandom);
        n_inflight = inflight;
        n_outp     = outp;
        if (c == done_at && !timed && in_wait) begin
          q.push_back({i_score, i_pix_flat});
          n_outp = 1'b1;
        end
        if (s_valid && !inflight) begin
          acc_c = c; lz1 = s_z1; lz2 = s_z2; n_inflight = 1'b1;
        end
        if (outp && m_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          n_outp = 1'b0; n_inflight = 1'b0; exp_cnt = exp_cnt + 1'b1;
        end
        if (timed && in_wait && c == wait_end) begin
          n_inflight = 1'b0; exp_err = 1'b1;
        end
        inflight = n_inflight;
        outp = n_outp;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
